avm_seq_master: RTL and testbench
=================================

Name: avm_seq_master

Overview:
Parametrised Avalon-MM sequencing master that generalises the fixed 10-bit/32-bit simple master. It runs a programmable block of word transfers against on-chip RAM: pattern fill, read-only sweep, or fill-then-verify. It honours waitrequest, counts mismatches and drives an 8-bit conduit export with the low byte of the last read word. It sits between control logic (switches/HPS PIO) and the OCRAM slave port in the Qsys system.

Parameters:
ADDR_W, 10, Avalon address width
DATA_W, 32, Avalon data width (8..64)
LEN_W, 10, width of word-count and error-count fields
ADDR_STRIDE, 4, address increment per word (4 = byte-addressed 32-bit slave, 1 = word-addressed)

Ports:
clk_clk  in  1  sole clock, all logic on rising edge
reset_reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request; sampled only in IDLE
mode  in  2  00 fill, 01 read sweep, 10 fill-then-verify, 11 treated as 01
base_addr  in  ADDR_W  first transfer address
length  in  LEN_W  number of words
seed  in  DATA_W  pattern seed
busy  out  1  high from the cycle after accepted start until the done cycle
done  out  1  one-cycle pulse at completion
err_count  out  LEN_W  verify mismatches, saturating
first_err_addr  out  ADDR_W  address of the first mismatch
avm_m0_address  out  ADDR_W  Avalon address
avm_m0_read  out  1  Avalon read
avm_m0_write  out  1  Avalon write
avm_m0_writedata  out  DATA_W  Avalon write data
avm_m0_waitrequest  in  1  slave stall
avm_m0_readdata  in  DATA_W  valid when read=1 and waitrequest=0
conduit_export  out  8  readdata[7:0] of the last completed read

Behaviour:
- Reset: every output is 0 and the state is IDLE at the next edge. A reset during a transfer abandons it immediately; dropping read/write mid-stall is permitted only under reset.
- States: IDLE, WR, RD, DONE.
- IDLE:
  - start=1 latches mode, base_addr, length and seed.
  - It clears err_count, first_err_addr and conduit_export, and sets idx=0.
  - length=0 goes to DONE. Mode 00/10 goes to WR; mode 01/11 goes to RD.
  - start is ignored in every other state.
- WR:
  - write=1, address=base+idx*ADDR_STRIDE mod 2^ADDR_W, writedata=seed+idx mod 2^DATA_W.
  - Address and data are held stable while waitrequest=1.
  - On an edge with waitrequest=0, the word is accepted and idx increments.
  - After the last word: mode 10 goes to RD with idx=0; mode 00 goes to DONE.
- RD:
  - read=1 with the same address rule. There is no pipelining: the read completes on an edge with waitrequest=0, and readdata is captured on that edge.
  - conduit_export gets readdata[7:0].
  - In mode 10, if readdata != seed+idx, err_count increments (saturates at all-ones). If this is the first error of the run, first_err_addr gets the current address.
  - After the last word, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- read and write are never asserted in the same cycle. Both are 0 in IDLE and DONE.
- Timing: the first command appears the cycle after start. Zero-wait throughput is 1 word per cycle. Total zero-wait latency from start to done is 1+N (fill/read) or 1+2N (verify) cycles.
- Address wraps modulo 2^ADDR_W without error.
- err_count, first_err_addr and conduit_export hold their values until the next accepted start.

Decomposition:
- Shared package avm_seq_pkg: mode enum (MODE_FILL, MODE_READ, MODE_VERIFY), state enum (S_IDLE, S_WR, S_RD, S_DONE), and the default width constants.
- One sub-module, avm_seq_addr_gen: holds the idx counter, base and stride address computation, expected-data (seed+idx) generation, and the last-word flag. The top level keeps the FSM, the Avalon outputs and the error tracking.

Test Plan:
- Fill, zero wait: mode 00, base 0x010, length 4, seed 0xA5. Required: writes to 0x010/0x014/0x018/0x01C with data 0xA5/0xA6/0xA7/0xA8 on consecutive cycles 1-4, done pulse on cycle 5.
- Verify with stalls: mode 10, length 3, slave model holds waitrequest 2 cycles on every access. Required: address and data stable during stalls, reads return the written data, err_count=0, conduit_export=low byte of seed+2.
- Mismatch: mode 10, base 0x020, seed 0, slave corrupts the word at 0x024 and 0x028. Required: err_count=2, first_err_addr=0x024.
- Zero length and ignored start: length 0 gives done on cycle 1 with no read/write. A second start pulsed mid-run is ignored, with a single done pulse.
- Reset mid-run: reset_reset during WR with waitrequest=1. Required: next edge has read=write=busy=done=0 and counters 0; a later start runs normally.
- Wrap and mode 11: base 0x3FC, length 2, mode 11. Required: reads at 0x3FC then 0x000, err_count stays 0.

Source files
------------

// File: rtl/avm_seq_pkg.sv
// Shared types and default widths for the Avalon-MM sequencing master.
// The FSM and the address/pattern generator both use these definitions.
package avm_seq_pkg;

  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_LEN_W       = 10;
  localparam int DEF_ADDR_STRIDE = 4;

  typedef enum logic [1:0] {
    MODE_FILL   = 2'b00,
    MODE_READ   = 2'b01,
    MODE_VERIFY = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WR   = 2'b01,
    S_RD   = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // The reserved encoding 11 behaves as a plain read sweep.
  function automatic mode_t decode_mode(input logic [1:0] m);
    if (m[0]) return MODE_READ;
    else if (m[1]) return MODE_VERIFY;
    else return MODE_FILL;
  endfunction

endpackage

// File: rtl/avm_seq_master_if.sv
// Avalon-MM master bus bundle between the sequencing master and the OCRAM slave.
interface avm_seq_master_if
  import avm_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [ADDR_W-1:0] avm_m0_address;
  logic              avm_m0_read;
  logic              avm_m0_write;
  logic [DATA_W-1:0] avm_m0_writedata;
  logic              avm_m0_waitrequest;
  logic [DATA_W-1:0] avm_m0_readdata;

  modport master (
    output avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    input  avm_m0_waitrequest, avm_m0_readdata
  );

  modport slave (
    input  avm_m0_address, avm_m0_read, avm_m0_write, avm_m0_writedata,
    output avm_m0_waitrequest, avm_m0_readdata
  );

endinterface

// File: rtl/avm_seq_addr_gen.sv
// Word index counter plus derived address, expected pattern word and last-word flag.
// Block parameters (base, length, seed) are captured once per accepted start.
module avm_seq_addr_gen
  import avm_seq_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic              restart_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(ADDR_STRIDE);

  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] seed_q;

  always_comb begin
    idx_d = idx_q;
    if (load_i || restart_i) idx_d = '0;
    else if (advance_i)      idx_d = idx_q + LEN_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      base_q <= base_i;
      len_q  <= len_i;
      seed_q <= seed_i;
    end
  end

  // Both sums wrap naturally at their port widths.
  assign addr_o = base_q + ADDR_W'(idx_q) * STRIDE;
  assign data_o = seed_q + DATA_W'(idx_q);
  assign last_o = (idx_q == len_q - LEN_W'(1));

endmodule

// File: rtl/avm_seq_master.sv
// Avalon-MM sequencing master: pattern fill, read sweep or fill-then-verify over a block
// of words, with waitrequest handling, saturating mismatch count and a readdata byte export.
module avm_seq_master
  import avm_seq_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        conduit_export,
  avm_seq_master_if.master  avm
);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [LEN_W-1:0]  err_q;
  logic [ADDR_W-1:0] first_q;
  logic [7:0]        conduit_q;

  logic              load, advance, restart, last;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] exp_data;
  logic              rd_ack, mismatch;

  avm_seq_addr_gen #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .LEN_W       (LEN_W),
    .ADDR_STRIDE (ADDR_STRIDE)
  ) u_addr_gen (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .load_i    (load),
    .advance_i (advance),
    .restart_i (restart),
    .base_i    (base_addr),
    .len_i     (length),
    .seed_i    (seed),
    .addr_o    (addr),
    .data_o    (exp_data),
    .last_o    (last)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    restart = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (length == '0)  state_d = S_DONE;
          else if (mode[0])  state_d = S_RD;
          else               state_d = S_WR;
        end
      end
      S_WR: begin
        if (!avm.avm_m0_waitrequest) begin
          advance = 1'b1;
          if (last) begin
            // Verify re-walks the same block from word 0 for the read-back pass.
            if (mode_q == MODE_VERIFY) begin
              restart = 1'b1;
              state_d = S_RD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_RD: begin
        if (!avm.avm_m0_waitrequest) begin
          advance = 1'b1;
          if (last) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_ack   = (state_q == S_RD) && !avm.avm_m0_waitrequest;
  assign mismatch = rd_ack && (mode_q == MODE_VERIFY) && (avm.avm_m0_readdata != exp_data);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_FILL;
      err_q     <= '0;
      first_q   <= '0;
      conduit_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q    <= decode_mode(mode);
        err_q     <= '0;
        first_q   <= '0;
        conduit_q <= '0;
      end
      if (rd_ack) conduit_q <= avm.avm_m0_readdata[7:0];
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + LEN_W'(1);
        // A saturated count is never zero, so zero reliably means "no error yet".
        if (err_q == '0) first_q <= addr;
      end
    end
  end

  assign busy           = (state_q == S_WR) || (state_q == S_RD);
  assign done           = (state_q == S_DONE);
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign conduit_export = conduit_q;

  always_comb begin
    avm.avm_m0_write     = (state_q == S_WR);
    avm.avm_m0_read      = (state_q == S_RD);
    avm.avm_m0_address   = busy ? addr : '0;
    avm.avm_m0_writedata = (state_q == S_WR) ? exp_data : '0;
  end

endmodule

// File: tb/tb_avm_seq_master.sv
// Self-checking bench for avm_seq_master: OCRAM slave model with programmable stalls,
// transaction logger and a block-level reference model of the expected traffic.
`timescale 1ns/1ps
module tb_avm_seq_master;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 10;

  logic clk = 1'b0;
  logic rst, start;
  logic [1:0]    mode;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic [DW-1:0] seed;
  logic          busy, done;
  logic [LW-1:0] err_count;
  logic [AW-1:0] first_err;
  logic [7:0]    conduit;

  avm_seq_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  avm_seq_master #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ADDR_STRIDE(4)) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .start          (start),
    .mode           (mode),
    .base_addr      (base),
    .length         (len),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err),
    .conduit_export (conduit),
    .avm            (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- slave model and monitor ----------------
  logic [31:0] smem [256];
  bit          swrote [256];
  bit          corrupt [256];
  int          stall_n = 0;
  int          st_cnt = 0;
  int          k;
  int          edge_n = 0;
  int          start_edge = 0;
  int          busy_n = 0;
  int          viol = 0;
  bit          p_stall = 1'b0;
  logic        p_rd, p_wr;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wd;

  int          w_addr[$], w_cyc[$], r_addr[$], r_cyc[$], done_cyc[$];
  logic [31:0] w_data[$];

  function automatic logic [31:0] init_word(input int j);
    return (32'(j) * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  always_comb begin
    k = int'(bus.avm_m0_address[9:2]);
    bus.avm_m0_waitrequest = (bus.avm_m0_read || bus.avm_m0_write) && (st_cnt < stall_n);
    bus.avm_m0_readdata = (swrote[k] ? smem[k] : init_word(k)) ^ (corrupt[k] ? 32'h1 : 32'h0);
  end

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (!rst && bus.avm_m0_write && !bus.avm_m0_waitrequest) begin
      smem[k]   <= bus.avm_m0_writedata;
      swrote[k] <= 1'b1;
      w_addr.push_back(int'(bus.avm_m0_address));
      w_data.push_back(bus.avm_m0_writedata);
      w_cyc.push_back(edge_n - start_edge);
    end
    if (!rst && bus.avm_m0_read && !bus.avm_m0_waitrequest) begin
      r_addr.push_back(int'(bus.avm_m0_address));
      r_cyc.push_back(edge_n - start_edge);
    end
    if (done) done_cyc.push_back(edge_n - start_edge);
    if (busy) busy_n <= busy_n + 1;
    if ((bus.avm_m0_read && bus.avm_m0_write) || (busy && done)) viol <= viol + 1;
    else if (p_stall && !(bus.avm_m0_address == p_addr && bus.avm_m0_writedata == p_wd &&
                          bus.avm_m0_read == p_rd && bus.avm_m0_write == p_wr)) viol <= viol + 1;
    if (bus.avm_m0_read || bus.avm_m0_write) st_cnt <= bus.avm_m0_waitrequest ? st_cnt + 1 : 0;
    else st_cnt <= 0;
    p_stall <= !rst && (bus.avm_m0_read || bus.avm_m0_write) && bus.avm_m0_waitrequest;
    p_rd    <= bus.avm_m0_read;
    p_wr    <= bus.avm_m0_write;
    p_addr  <= bus.avm_m0_address;
    p_wd    <= bus.avm_m0_writedata;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [256];
  bit          ref_wrote [256];
  int          e_w_addr[$], e_w_cyc[$], e_r_addr[$], e_r_cyc[$];
  logic [31:0] e_w_data[$];
  int          e_done, e_err, e_first;
  logic [7:0]  e_conduit;

  task automatic model_run(input int m, input int b, input int n, input logic [31:0] s, input int stall);
    int nwr, nrd, per, a;
    logic [31:0] rd;
    e_w_addr.delete(); e_w_data.delete(); e_w_cyc.delete();
    e_r_addr.delete(); e_r_cyc.delete();
    e_err = 0; e_first = 0; e_conduit = 8'h00;
    nwr = (m == 0 || m == 2) ? n : 0;
    nrd = (m == 0) ? 0 : n;
    per = stall + 1;
    for (int i = 0; i < nwr; i++) begin
      a = (b + 4 * i) % 1024;
      e_w_addr.push_back(a);
      e_w_data.push_back(s + 32'(i));
      e_w_cyc.push_back((i + 1) * per);
      ref_mem[a / 4]   = s + 32'(i);
      ref_wrote[a / 4] = 1'b1;
    end
    for (int i = 0; i < nrd; i++) begin
      a  = (b + 4 * i) % 1024;
      rd = (ref_wrote[a / 4] ? ref_mem[a / 4] : init_word(a / 4)) ^ (corrupt[a / 4] ? 32'h1 : 32'h0);
      e_r_addr.push_back(a);
      e_r_cyc.push_back((nwr + i + 1) * per);
      e_conduit = rd[7:0];
      if (m == 2 && rd != s + 32'(i)) begin
        if (e_err == 0) e_first = a;
        if (e_err < 1023) e_err++;
      end
    end
    e_done = (nwr + nrd) * per + 1;
  endtask

  // ---------------- stimulus driver ----------------
  int wb, rb, db, bb, vb;

  task automatic do_run(input int m, input int b, input int n, input logic [31:0] s,
                        input int restart_at, output bit to);
    @(negedge clk);
    mode = 2'(m); base = AW'(b); len = LW'(n); seed = s; start = 1'b1;
    start_edge = edge_n;
    wb = w_addr.size(); rb = r_addr.size(); db = done_cyc.size(); bb = busy_n; vb = viol;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom); base = AW'($urandom); len = LW'($urandom); seed = $urandom;
    to = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      start = (c == restart_at);
      @(negedge clk);
      if (done_cyc.size() > db) begin
        to = 1'b0;
        break;
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, bus.avm_m0_read, bus.avm_m0_write} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, want 0000", {busy, done, bus.avm_m0_read, bus.avm_m0_write});
    end
    checks++;
    if ({bus.avm_m0_address, bus.avm_m0_writedata} !== '0) begin
      errors++; $display("FAIL reset_bus: got addr=%0h wd=%0h, want 0", bus.avm_m0_address, bus.avm_m0_writedata);
    end
    checks++;
    if ({err_count, first_err, conduit} !== '0) begin
      errors++; $display("FAIL reset_status: got err=%0d first=%0h cond=%0h, want 0", err_count, first_err, conduit);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    bit to;
    stall_n = 0;
    model_run(0, 'h010, 4, 32'hA5, 0);
    do_run(0, 'h010, 4, 32'hA5, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL fill_timeout: got no done, want done"); end
    checks++;
    if (w_addr.size() - wb !== 4 || r_addr.size() - rb !== 0) begin
      errors++; $display("FAIL fill_count: got w=%0d r=%0d, want w=4 r=0", w_addr.size() - wb, r_addr.size() - rb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= w_addr.size() || w_addr[wb + i] !== 'h010 + 4 * i ||
          w_data[wb + i] !== 32'hA5 + 32'(i) || w_cyc[wb + i] !== i + 1) begin
        errors++; $display("FAIL fill_write[%0d]: got a=%0h d=%0h c=%0d, want a=%0h d=%0h c=%0d", i,
                           w_addr[wb + i], w_data[wb + i], w_cyc[wb + i], 'h010 + 4 * i, 32'hA5 + 32'(i), i + 1);
      end
    end
    checks++;
    if (done_cyc.size() - db !== 1 || done_cyc[db] !== 5) begin
      errors++; $display("FAIL fill_done: got n=%0d cyc=%0d, want n=1 cyc=5", done_cyc.size() - db, done_cyc[db]);
    end
    checks++;
    if (busy_n - bb !== 4) begin errors++; $display("FAIL fill_busy: got %0d cycles, want 4", busy_n - bb); end
  endtask

  task automatic test_verify_stall();
    bit to;
    stall_n = 2;
    model_run(2, 'h100, 3, 32'h1234_5670, 2);
    do_run(2, 'h100, 3, 32'h1234_5670, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL vs_timeout: got no done, want done"); end
    checks++;
    if (w_addr.size() - wb !== 3 || r_addr.size() - rb !== 3) begin
      errors++; $display("FAIL vs_count: got w=%0d r=%0d, want 3 3", w_addr.size() - wb, r_addr.size() - rb);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wb + i >= w_addr.size() || rb + i >= r_addr.size() || w_addr[wb + i] !== e_w_addr[i] ||
          w_data[wb + i] !== e_w_data[i] || w_cyc[wb + i] !== e_w_cyc[i] ||
          r_addr[rb + i] !== e_r_addr[i] || r_cyc[rb + i] !== e_r_cyc[i]) begin
        errors++; $display("FAIL vs_xfer[%0d]: got wa=%0h wd=%0h wc=%0d ra=%0h rc=%0d, want %0h %0h %0d %0h %0d", i,
                           w_addr[wb + i], w_data[wb + i], w_cyc[wb + i], r_addr[rb + i], r_cyc[rb + i],
                           e_w_addr[i], e_w_data[i], e_w_cyc[i], e_r_addr[i], e_r_cyc[i]);
      end
    end
    checks++;
    if (viol - vb !== 0) begin errors++; $display("FAIL vs_stable: got %0d violations, want 0", viol - vb); end
    checks++;
    if (err_count !== 0 || conduit !== 8'h72) begin
      errors++; $display("FAIL vs_status: got err=%0d cond=%0h, want err=0 cond=72", err_count, conduit);
    end
    checks++;
    if (done_cyc.size() - db !== 1 || done_cyc[db] !== 19) begin
      errors++; $display("FAIL vs_done: got n=%0d cyc=%0d, want n=1 cyc=19", done_cyc.size() - db, done_cyc[db]);
    end
  endtask

  task automatic test_mismatch();
    bit to;
    stall_n = 1;
    corrupt['h24 / 4] = 1'b1;
    corrupt['h28 / 4] = 1'b1;
    model_run(2, 'h020, 4, 32'h0, 1);
    do_run(2, 'h020, 4, 32'h0, -1, to);
    checks++;
    if (to) begin errors++; $display("FAIL mm_timeout: got no done, want done"); end
    checks++;
    if (err_count !== 10'd2 || first_err !== 10'h024) begin
      errors++; $display("FAIL mm_errs: got err=%0d first=%0h, want err=2 first=24", err_count, first_err);
    end
    checks++;
    if (done_cyc[db] !== e_done) begin errors++; $display("FAIL mm_done: got %0d, want %0d", done_cyc[db], e_done); end
    corrupt['h24 / 4] = 1'b0;
    corrupt['h28 / 4] = 1'b0;
  endtask

  task automatic test_zero_and_ignored();
    bit to;
    stall_n = 0;
    model_run(0, 'h300, 0, 32'h5, 0);
    do_run(0, 'h300, 0, 32'h5, -1, to);
    checks++;
    if (to || done_cyc[db] !== 1 || done_cyc.size() - db !== 1) begin
      errors++; $display("FAIL zl_done: got to=%0d cyc=%0d n=%0d, want 0 1 1", to, done_cyc[db], done_cyc.size() - db);
    end
    checks++;
    if (w_addr.size() - wb !== 0 || r_addr.size() - rb !== 0 || busy_n - bb !== 0) begin
      errors++; $display("FAIL zl_traffic: got w=%0d r=%0d busy=%0d, want 0 0 0", w_addr.size() - wb, r_addr.size() - rb, busy_n - bb);
    end
    stall_n = 1;
    model_run(0, 'h040, 4, 32'h77, 1);
    do_run(0, 'h040, 4, 32'h77, 2, to);
    checks++;
    if (to || done_cyc.size() - db !== 1 || done_cyc[db] !== 9) begin
      errors++; $display("FAIL ig_done: got to=%0d n=%0d cyc=%0d, want 0 1 9", to, done_cyc.size() - db, done_cyc[db]);
    end
    checks++;
    if (w_addr.size() - wb !== 4 || r_addr.size() - rb !== 0 || w_addr[wb + 3] !== 'h04C || w_data[wb + 3] !== 32'h7A) begin
      errors++; $display("FAIL ig_traffic: got w=%0d r=%0d last=%0h/%0h, want 4 0 4c/7a",
                         w_addr.size() - wb, r_addr.size() - rb, w_addr[wb + 3], w_data[wb + 3]);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({err_count, first_err, conduit} !== '0) begin
      errors++; $display("FAIL rm_idle_clear: got err=%0d first=%0h cond=%0h, want 0", err_count, first_err, conduit);
    end
    stall_n = 100;
    @(negedge clk);
    mode = 2'b00; base = 'h080; len = 4; seed = 32'h33; start = 1'b1;
    start_edge = edge_n;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.avm_m0_write !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL rm_stalled: got wr=%b busy=%b, want 1 1", bus.avm_m0_write, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, bus.avm_m0_read, bus.avm_m0_write} !== 4'b0 || bus.avm_m0_address !== '0) begin
      errors++; $display("FAIL rm_abandon: got ctl=%b addr=%0h, want 0000 0",
                         {busy, done, bus.avm_m0_read, bus.avm_m0_write}, bus.avm_m0_address);
    end
    checks++;
    if ({err_count, first_err, conduit} !== '0) begin
      errors++; $display("FAIL rm_counters: got err=%0d first=%0h cond=%0h, want 0", err_count, first_err, conduit);
    end
    rst = 1'b0;
    stall_n = 0;
    @(negedge clk);
    model_run(0, 'h080, 4, 32'h33, 0);
    do_run(0, 'h080, 4, 32'h33, -1, to);
    checks++;
    if (to || done_cyc[db] !== 5 || w_addr.size() - wb !== 4) begin
      errors++; $display("FAIL rm_rerun: got to=%0d done=%0d w=%0d, want 0 5 4", to, done_cyc[db], w_addr.size() - wb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb + i >= w_addr.size() || w_addr[wb + i] !== 'h080 + 4 * i || w_data[wb + i] !== 32'h33 + 32'(i)) begin
        errors++; $display("FAIL rm_write[%0d]: got a=%0h d=%0h, want a=%0h d=%0h", i,
                           w_addr[wb + i], w_data[wb + i], 'h080 + 4 * i, 32'h33 + 32'(i));
      end
    end
  endtask

  task automatic test_wrap_mode11();
    bit to;
    stall_n = 0;
    model_run(3, 'h3FC, 2, 32'hCAFE_0001, 0);
    do_run(3, 'h3FC, 2, 32'hCAFE_0001, -1, to);
    checks++;
    if (to || w_addr.size() - wb !== 0 || r_addr.size() - rb !== 2) begin
      errors++; $display("FAIL wr_count: got to=%0d w=%0d r=%0d, want 0 0 2", to, w_addr.size() - wb, r_addr.size() - rb);
    end
    checks++;
    if (r_addr[rb] !== 'h3FC || r_addr[rb + 1] !== 'h000) begin
      errors++; $display("FAIL wr_addr: got %0h %0h, want 3fc 0", r_addr[rb], r_addr[rb + 1]);
    end
    checks++;
    if (err_count !== 0 || conduit !== e_conduit || done_cyc[db] !== 3) begin
      errors++; $display("FAIL wr_status: got err=%0d cond=%0h done=%0d, want 0 %0h 3", err_count, conduit, done_cyc[db], e_conduit);
    end
  endtask

  task automatic test_random();
    bit to;
    int m, b, n, st;
    logic [31:0] s;
    for (int it = 0; it < 10; it++) begin
      m = $urandom_range(0, 3); b = $urandom_range(0, 1023); n = $urandom_range(1, 9);
      st = $urandom_range(0, 2); s = $urandom;
      for (int j = 0; j < 256; j++) corrupt[j] = ($urandom_range(0, 5) == 0);
      stall_n = st;
      model_run(m, b, n, s, st);
      do_run(m, b, n, s, -1, to);
      checks++;
      if (to || w_addr.size() - wb !== e_w_addr.size() || r_addr.size() - rb !== e_r_addr.size()) begin
        errors++; $display("FAIL rnd%0d_count: got to=%0d w=%0d r=%0d, want 0 %0d %0d", it, to,
                           w_addr.size() - wb, r_addr.size() - rb, e_w_addr.size(), e_r_addr.size());
      end
      for (int i = 0; i < e_w_addr.size(); i++) begin
        checks++;
        if (wb + i >= w_addr.size() || w_addr[wb + i] !== e_w_addr[i] ||
            w_data[wb + i] !== e_w_data[i] || w_cyc[wb + i] !== e_w_cyc[i]) begin
          errors++; $display("FAIL rnd%0d_write[%0d]: got a=%0h d=%0h c=%0d, want a=%0h d=%0h c=%0d", it, i,
                             w_addr[wb + i], w_data[wb + i], w_cyc[wb + i], e_w_addr[i], e_w_data[i], e_w_cyc[i]);
        end
      end
      for (int i = 0; i < e_r_addr.size(); i++) begin
        checks++;
        if (rb + i >= r_addr.size() || r_addr[rb + i] !== e_r_addr[i] || r_cyc[rb + i] !== e_r_cyc[i]) begin
          errors++; $display("FAIL rnd%0d_read[%0d]: got a=%0h c=%0d, want a=%0h c=%0d", it, i,
                             r_addr[rb + i], r_cyc[rb + i], e_r_addr[i], e_r_cyc[i]);
        end
      end
      checks++;
      if (int'(err_count) !== e_err || int'(first_err) !== e_first || conduit !== e_conduit) begin
        errors++; $display("FAIL rnd%0d_status: got err=%0d first=%0h cond=%0h, want %0d %0h %0h", it,
                           err_count, first_err, conduit, e_err, e_first, e_conduit);
      end
      checks++;
      if (done_cyc.size() - db !== 1 || done_cyc[db] !== e_done || busy_n - bb !== e_done - 1 || viol - vb !== 0) begin
        errors++; $display("FAIL rnd%0d_timing: got n=%0d done=%0d busy=%0d viol=%0d, want 1 %0d %0d 0", it,
                           done_cyc.size() - db, done_cyc[db], busy_n - bb, viol - vb, e_done, e_done - 1);
      end
    end
    for (int j = 0; j < 256; j++) corrupt[j] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; base = '0; len = '0; seed = '0;
    test_reset();
    test_fill();
    test_verify_stall();
    test_mismatch();
    test_zero_and_ignored();
    test_reset_mid();
    test_wrap_mode11();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1);
  end

endmodule
